// File: rtl/seg_pkg.sv
// Shared glyph table, nibble decoder and conversion-state encoding
// for the multi-channel seven-segment scanner.
package seg_pkg;

   localparam logic [7:0] SEG_0     = 8'h3f;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5b;
   localparam logic [7:0] SEG_3     = 8'h4f;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6d;
   localparam logic [7:0] SEG_6     = 8'h7d;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7f;
   localparam logic [7:0] SEG_9     = 8'h6f;
   localparam logic [7:0] SEG_DASH  = 8'h40;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;

   // Codes 10..15 never come out of the BCD engine; they render dark.
   function automatic logic [7:0] seg_decode(input logic [3:0] nib);
      case (nib)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/seg_scan_multi_bin2bcd.sv
// Sequential double-dabble: one binary bit per clock, DATA_W+2 cycles
// from LOAD to the DONE cycle that presents the finished BCD word.
module bin2bcd_seq
   import seg_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NIB    = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] bin,
   output logic              busy,
   output logic              done,
   output logic [NIB*4-1:0]  bcd
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   conv_state_t       state;
   logic [DATA_W-1:0] sh;
   logic [CNT_W-1:0]  cnt;
   logic [NIB*4-1:0]  bcd_adj;

   always_comb begin
      bcd_adj = bcd;
      for (int n = 0; n < NIB; n++)
         if (bcd[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         sh    <= '0;
         cnt   <= '0;
         bcd   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state <= LOAD;
               busy  <= 1'b1;
            end
            LOAD: begin
               sh    <= bin;
               bcd   <= '0;
               cnt   <= '0;
               state <= SHIFT;
            end
            SHIFT: begin
               bcd <= {bcd_adj[NIB*4-2:0], sh[DATA_W-1]};
               sh  <= sh << 1;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(DATA_W-1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               done <= 1'b0;
               if (start) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/seg_scan_multi.sv
// Channel-select seven-segment scanner: sequential BCD conversion,
// prescaled digit multiplexing, blanking, overflow dash and polarity.
module seg_scan_multi
   import seg_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int DATA_W         = 16,
   parameter int CH             = 2,
   parameter int REFRESH_DIV    = 50000,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] ch_sel,
   input  logic [CH*DATA_W-1:0]                  data,
   input  logic [DIGITS-1:0]                     dp_mask,
   input  logic                                  blank_lz,
   input  logic                                  enable,
   output logic [7:0]                            seg,
   output logic [DIGITS-1:0]                     dig,
   output logic                                  conv_busy,
   output logic                                  overflow
);

   localparam int SEL_W    = (CH > 1) ? $clog2(CH) : 1;
   localparam int NIB_CALC = (DATA_W * 121 + 399) / 400;
   localparam int NIB      = (NIB_CALC > DIGITS) ? NIB_CALC : DIGITS;
   localparam int PRE_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [7:0]        SEG_POL = (SEG_ACTIVE_LOW != 0) ? 8'hff : 8'h00;
   localparam logic [DIGITS-1:0] DIG_POL = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   logic [DATA_W-1:0]   bin_sel;
   logic                conv_done;
   logic [NIB*4-1:0]    bcd;
   logic                hi_nz;
   logic [DIGITS*4-1:0] disp;
   logic [PRE_W-1:0]    pre;
   logic [IDX_W-1:0]    idx;
   logic [DIGITS-1:0]   blank;
   logic [3:0]          cur_nib;
   logic                cur_blank, cur_dp, run, dp_seen;
   logic [7:0]          glyph;
   logic [DIGITS-1:0]   dig_next;

   // Out-of-range selects fall back to channel 0.
   always_comb begin
      bin_sel = data[0 +: DATA_W];
      for (int i = 0; i < CH; i++)
         if (SEL_W'(i) == ch_sel) bin_sel = data[i*DATA_W +: DATA_W];
   end

   bin2bcd_seq #(.DATA_W(DATA_W), .NIB(NIB)) u_conv (
      .clk   (clk),
      .reset (reset),
      .start (1'b1),
      .bin   (bin_sel),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (bcd)
   );

   always_comb begin
      hi_nz = 1'b0;
      for (int n = DIGITS; n < NIB; n++) hi_nz = hi_nz | (bcd[n*4 +: 4] != 4'd0);
   end

   // Overflow freezes the last good digits; dashes hide them meanwhile.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp     <= '0;
         overflow <= 1'b0;
      end else if (conv_done) begin
         if (hi_nz) begin
            overflow <= 1'b1;
         end else begin
            overflow <= 1'b0;
            disp     <= bcd[DIGITS*4-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre <= '0;
         idx <= '0;
      end else if (pre == PRE_W'(REFRESH_DIV-1)) begin
         pre <= '0;
         idx <= (idx == IDX_W'(DIGITS-1)) ? '0 : idx + 1'b1;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   // Walk from the top digit down: blank while still in the zero run and
   // no decimal point has been requested at or above this position.
   always_comb begin
      run     = 1'b1;
      dp_seen = 1'b0;
      blank   = '0;
      for (int k = DIGITS-1; k >= 0; k--) begin
         run      = run & (disp[k*4 +: 4] == 4'd0);
         dp_seen  = dp_seen | dp_mask[k];
         blank[k] = blank_lz & (k > 0) & ~dp_seen & run;
      end
   end

   always_comb begin
      cur_nib   = 4'd0;
      cur_blank = 1'b0;
      cur_dp    = 1'b0;
      for (int k = 0; k < DIGITS; k++)
         if (IDX_W'(k) == idx) begin
            cur_nib   = disp[k*4 +: 4];
            cur_blank = blank[k];
            cur_dp    = dp_mask[k];
         end
      if (overflow)       glyph = SEG_DASH;
      else if (cur_blank) glyph = SEG_BLANK;
      else                glyph = seg_decode(cur_nib) | {cur_dp, 7'b0};
      dig_next = enable ? (DIGITS'(1) << idx) : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg <= SEG_POL;
         dig <= DIG_POL;
      end else begin
         seg <= glyph ^ SEG_POL;
         dig <= dig_next ^ DIG_POL;
      end
   end

endmodule

// File: tb/tb_seg_scan_multi.sv
// Directed bench for seg_scan_multi with a cycle-level arithmetic model
// of the displayed value and the scan position.
module tb_seg_scan_multi;

   localparam int D  = 4;
   localparam int W  = 16;
   localparam int R  = 4;
   localparam int PERIOD = W + 2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         ch_sel = 1'b0;
   logic [2*W-1:0] data = '0;
   logic [D-1:0] dp_mask = '0;
   logic         blank_lz = 1'b0;
   logic         enable = 1'b1;
   logic [7:0]   seg;
   logic [D-1:0] dig;
   logic         conv_busy;
   logic         overflow;

   int n_chk = 0;
   int n_fail = 0;

   seg_scan_multi #(
      .DIGITS(D), .DATA_W(W), .CH(2), .REFRESH_DIV(R),
      .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .reset(reset), .ch_sel(ch_sel), .data(data),
      .dp_mask(dp_mask), .blank_lz(blank_lz), .enable(enable),
      .seg(seg), .dig(dig), .conv_busy(conv_busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   logic [7:0] gly [0:9] = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07, 8'h7f, 8'h6f};
   int   dv [D];
   int   n_edge, mval, mpos, midx;
   bit   mov;
   logic [7:0]   e_seg;
   logic [D-1:0] e_dig;
   logic         e_busy, e_ov;

   function automatic logic [7:0] exp_glyph(input int k);
      int  h;
      bit  z;
      h = -1;
      for (int j = 0; j < D; j++) if (dp_mask[j]) h = j;
      z = 1'b1;
      for (int j = k; j < D; j++) if (dv[j] != 0) z = 1'b0;
      if (mov) return 8'h40;
      if (blank_lz && k > 0 && k > h && z) return 8'h00;
      return gly[dv[k]] | (dp_mask[k] ? 8'h80 : 8'h00);
   endfunction

   always begin
      @(posedge clk);
      if (reset) begin
         n_edge = 0;
         mov    = 1'b0;
         for (int k = 0; k < D; k++) dv[k] = 0;
         e_seg  = 8'h00;
         e_dig  = '1;
         e_busy = 1'b0;
         e_ov   = 1'b0;
      end else begin
         // One conversion every PERIOD cycles, starting one cycle after reset.
         mpos  = (n_edge == 0) ? -1 : (n_edge - 1) % PERIOD;
         midx  = (n_edge / R) % D;
         e_seg = exp_glyph(midx);
         e_dig = enable ? ~(D'(1) << midx) : '1;
         if (mpos == 0) mval = ch_sel ? int'(data[2*W-1:W]) : int'(data[W-1:0]);
         if (mpos == PERIOD - 1) begin
            if (mval >= 10 ** D) mov = 1'b1;
            else begin
               mov = 1'b0;
               for (int k = 0; k < D; k++) dv[k] = (mval / (10 ** k)) % 10;
            end
         end
         e_ov   = mov;
         n_edge = n_edge + 1;
         e_busy = ((n_edge - 1) % PERIOD) <= W;
      end
      #1;
      chk("model_seg", seg, e_seg);
      chk("model_dig", dig, e_dig);
      chk("model_busy", conv_busy, e_busy);
      chk("model_ovf", overflow, e_ov);
   end

   // ---------------- directed helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_slot(input int k, input logic [7:0] exp, input string nm);
      logic [D-1:0] want;
      int t;
      want = ~(D'(1) << k);
      t = 0;
      while (dig !== want && t < 64) begin @(negedge clk); t++; end
      if (t >= 64) chk({nm, "_timeout"}, dig, want);
      else chk(nm, seg, exp);
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (!conv_busy && t < 60) begin @(negedge clk); t++; end
      while (conv_busy && t < 60) begin @(negedge clk); t++; end
      if (t >= 60) chk("conv_timeout", t, 0);
   endtask

   initial begin
      data[W-1:0] = 16'd1234;
      tick(3);
      chk("rst_seg", seg, 8'h00);
      chk("rst_dig", dig, 4'b1111);
      chk("rst_busy", conv_busy, 1'b0);
      reset = 1'b0;

      // 1: first conversion, slot glyphs and wrap
      tick(24);
      chk_slot(0, 8'h66, "t1_slot0");
      chk_slot(3, 8'h06, "t1_slot3");
      chk_slot(0, 8'h66, "t1_wrap_slot0");

      // 2: selection change mid-SHIFT applies only to the next LOAD
      wait_done();
      data[W-1:0]   = 16'd2468;
      data[2*W-1:W] = 16'd7;
      tick(4);
      ch_sel = 1'b1;
      wait_done();
      tick(2);
      chk_slot(3, 8'h5b, "t2_old_ch_slot3");
      wait_done();
      tick(2);
      chk_slot(0, 8'h07, "t2_new_slot0");
      chk_slot(3, 8'h3f, "t2_new_slot3");

      // 3: leading-zero blanking with and without a decimal point
      blank_lz = 1'b1;
      tick(2);
      chk_slot(3, 8'h00, "t3_blank3");
      chk_slot(1, 8'h00, "t3_blank1");
      chk_slot(0, 8'h07, "t3_digit0");
      dp_mask = 4'b0100;
      tick(2);
      chk_slot(3, 8'h00, "t3_dp_blank3");
      chk_slot(2, 8'hbf, "t3_dp_digit2");
      chk_slot(1, 8'h3f, "t3_dp_digit1");
      chk_slot(0, 8'h07, "t3_dp_digit0");

      // 4: overflow at 10^DIGITS, recovery at 9999
      data[2*W-1:W] = 16'd10000;
      wait_done(); wait_done(); tick(2);
      chk("t4_ovf", overflow, 1'b1);
      for (int k = 0; k < D; k++) chk_slot(k, 8'h40, "t4_dash");
      dp_mask = '0;
      data[2*W-1:W] = 16'd9999;
      wait_done(); wait_done(); tick(2);
      chk("t4_ovf_clr", overflow, 1'b0);
      for (int k = 0; k < D; k++) chk_slot(k, 8'h6f, "t4_nines");

      // 5: asynchronous reset in the middle of a conversion
      blank_lz = 1'b0;
      wait_done();
      while (!conv_busy) @(negedge clk);
      tick(5);
      #2 reset = 1'b1;
      #1;
      chk("t5_busy", conv_busy, 1'b0);
      chk("t5_seg", seg, 8'h00);
      chk("t5_dig", dig, 4'b1111);
      chk("t5_ovf", overflow, 1'b0);
      tick(2);
      reset = 1'b0;
      chk_slot(3, 8'h3f, "t5_zero_slot3");
      wait_done(); tick(2);
      chk_slot(1, 8'h6f, "t5_after_done");

      // 6: display disabled for ten slots while the scan keeps moving
      begin
         logic [D-1:0] prev;
         int t;
         prev = dig;
         t = 0;
         while (t < 64) begin
            @(negedge clk); t++;
            if (dig == 4'b1110 && prev != 4'b1110) break;
            prev = dig;
         end
         if (t >= 64) chk("t6_sync_timeout", dig, 4'b1110);
      end
      enable = 1'b0;
      for (int i = 0; i < 10 * R; i++) begin
         @(negedge clk);
         chk("t6_dig_off", dig, 4'b1111);
      end
      enable = 1'b1;
      tick(1);
      chk("t6_resume_slot2", dig, 4'b1011);
      tick(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
